// File: rtl/i2c_byte_sequencer_if.sv
// i2c_byte_sequencer_if: command, response, pad and shift-register bundle.
// master = the sequencer, slave = front end / pads / shift register.
interface i2c_byte_sequencer_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 16
);
   logic [PRESCALE_WIDTH-1:0] i_prescale;
   logic                      i_cmd_valid;
   logic                      o_cmd_ready;
   logic [1:0]                i_cmd;
   logic                      i_cmd_ack_en;
   logic [DATA_WIDTH-1:0]     i_tx_data;
   logic                      o_rsp_valid;
   logic                      o_rsp_err;
   logic [DATA_WIDTH-1:0]     o_rx_data;
   logic                      o_ack_received;
   logic                      o_busy;
   logic                      o_bus_owned;
   logic                      o_scl_oe;
   logic                      o_sda_oe;
   logic                      i_sda_in;
   logic                      o_sr_load;
   logic [DATA_WIDTH-1:0]     o_sr_parallel_in;
   logic                      o_sr_shift_en;
   logic                      o_sr_rw_mode;
   logic                      o_sr_ack_en;
   logic                      i_sr_serial_out;
   logic [DATA_WIDTH-1:0]     i_sr_parallel_out;

   modport master (
      input  i_prescale, i_cmd_valid, i_cmd, i_cmd_ack_en, i_tx_data,
      input  i_sda_in, i_sr_serial_out, i_sr_parallel_out,
      output o_cmd_ready, o_rsp_valid, o_rsp_err, o_rx_data,
      output o_ack_received, o_busy, o_bus_owned, o_scl_oe, o_sda_oe,
      output o_sr_load, o_sr_parallel_in, o_sr_shift_en,
      output o_sr_rw_mode, o_sr_ack_en
   );

   modport slave (
      output i_prescale, i_cmd_valid, i_cmd, i_cmd_ack_en, i_tx_data,
      output i_sda_in, i_sr_serial_out, i_sr_parallel_out,
      input  o_cmd_ready, o_rsp_valid, o_rsp_err, o_rx_data,
      input  o_ack_received, o_busy, o_bus_owned, o_scl_oe, o_sda_oe,
      input  o_sr_load, o_sr_parallel_in, o_sr_shift_en,
      input  o_sr_rw_mode, o_sr_ack_en
   );
endinterface

// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer: command-driven I2C master bit-timing controller.
// Sequences START/STOP/byte transfers and the byte shift-register strobes.
module i2c_byte_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input logic                  i_sys_clk,
   input logic                  i_rst,
   i2c_byte_sequencer_if.master bus
);

   localparam logic [1:0] CMD_START = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_STOP  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_PREP, S_DATA, S_ACK, S_STOP, S_RESP
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                cmd_q, cmd_d;
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic [PRESCALE_WIDTH-1:0] qcnt_q, qcnt_d;
   logic [1:0]                qph_q, qph_d;
   logic [2:0]                bit_q, bit_d;
   logic [1:0]                prep_q, prep_d;
   logic [DATA_WIDTH-1:0]     tx_q, tx_d;
   logic                      ack_en_q, ack_en_d;
   logic                      sda_bit_q, sda_bit_d;
   logic                      ack_smp_q, ack_smp_d;
   logic                      owned_q, owned_d;
   logic                      hold_sda_q, hold_sda_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0]     rx_q, rx_d;
   logic                      ack_rx_q, ack_rx_d;

   logic qend, phase_first, bit_end, is_read;
   logic scl_oe, sda_oe, sr_load, sr_shift;

   assign qend        = (qcnt_q == presc_q);
   assign phase_first = (qcnt_q == '0) && (qph_q == 2'd0);
   assign bit_end     = qend && (qph_q == 2'd3);
   assign is_read     = (cmd_q == CMD_READ);

   // Next-state: command accept, quarter/bit counting, response capture
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      presc_d    = presc_q;
      qcnt_d     = qcnt_q;
      qph_d      = qph_q;
      bit_d      = bit_q;
      prep_d     = prep_q;
      tx_d       = tx_q;
      ack_en_d   = ack_en_q;
      sda_bit_d  = sda_bit_q;
      ack_smp_d  = ack_smp_q;
      owned_d    = owned_q;
      hold_sda_d = hold_sda_q;
      rsp_err_d  = rsp_err_q;
      rx_d       = rx_q;
      ack_rx_d   = ack_rx_q;
      if (state_q inside {S_START, S_STOP, S_DATA, S_ACK}) begin
         qcnt_d = qend ? '0 : qcnt_q + 1'b1;
         if (qend) qph_d = qph_q + 2'd1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (bus.i_cmd_valid) begin
               cmd_d    = bus.i_cmd;
               presc_d  = bus.i_prescale;
               tx_d     = bus.i_tx_data;
               ack_en_d = bus.i_cmd_ack_en;
               qcnt_d   = '0;
               qph_d    = 2'd0;
               bit_d    = 3'd0;
               prep_d   = 2'd0;
               case (bus.i_cmd)
                  CMD_START: state_d = S_START;
                  CMD_STOP:  state_d = owned_q ? S_STOP : S_RESP;
                  default:   state_d = owned_q ? S_PREP : S_RESP;
               endcase
               // Anything but START needs an owned bus
               if (bus.i_cmd != CMD_START && !owned_q) begin
                  rsp_err_d = 1'b1;
                  ack_rx_d  = 1'b0;
               end
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d    = S_RESP;
               owned_d    = 1'b1;
               hold_sda_d = 1'b1;
               rsp_err_d  = 1'b0;
               ack_rx_d   = 1'b0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d    = S_RESP;
               owned_d    = 1'b0;
               hold_sda_d = 1'b0;
               rsp_err_d  = 1'b0;
               ack_rx_d   = 1'b0;
            end
         end
         S_PREP: begin
            prep_d = prep_q + 2'd1;
            if (prep_q == 2'd2) state_d = S_DATA;
         end
         S_DATA: begin
            if (phase_first) sda_bit_d = ~bus.i_sr_serial_out;
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (qend && qph_q == 2'd2) ack_smp_d = ~bus.i_sda_in;
            if (bit_end) begin
               state_d    = S_RESP;
               hold_sda_d = 1'b0;
               rsp_err_d  = 1'b0;
               ack_rx_d   = (cmd_q == CMD_WRITE) ? ack_smp_q : 1'b0;
               if (is_read) rx_d = bus.i_sr_parallel_out;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Line drive and strobes decoded from state and quarter phase
   always_comb begin
      scl_oe   = owned_q;
      sda_oe   = hold_sda_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      unique case (state_q)
         S_START: begin
            scl_oe = (qph_q == 2'd0) || (qph_q == 2'd3);
            sda_oe = qph_q[1];
         end
         S_STOP: begin
            scl_oe = (qph_q == 2'd0);
            sda_oe = ~qph_q[1];
         end
         S_PREP: sr_load = (prep_q == 2'd0);
         S_DATA: begin
            scl_oe   = ~qph_q[1];
            sda_oe   = is_read ? 1'b0 :
                       (phase_first ? ~bus.i_sr_serial_out : sda_bit_q);
            sr_shift = qend && (qph_q == 2'd2);
         end
         S_ACK: begin
            scl_oe   = ~qph_q[1];
            sda_oe   = is_read & ack_en_q;
            sr_shift = phase_first;
         end
         default: ;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         cmd_q      <= 2'd0;
         presc_q    <= '0;
         qcnt_q     <= '0;
         qph_q      <= 2'd0;
         bit_q      <= 3'd0;
         prep_q     <= 2'd0;
         tx_q       <= '0;
         ack_en_q   <= 1'b0;
         sda_bit_q  <= 1'b0;
         ack_smp_q  <= 1'b0;
         owned_q    <= 1'b0;
         hold_sda_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rx_q       <= '0;
         ack_rx_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         presc_q    <= presc_d;
         qcnt_q     <= qcnt_d;
         qph_q      <= qph_d;
         bit_q      <= bit_d;
         prep_q     <= prep_d;
         tx_q       <= tx_d;
         ack_en_q   <= ack_en_d;
         sda_bit_q  <= sda_bit_d;
         ack_smp_q  <= ack_smp_d;
         owned_q    <= owned_d;
         hold_sda_q <= hold_sda_d;
         rsp_err_q  <= rsp_err_d;
         rx_q       <= rx_d;
         ack_rx_q   <= ack_rx_d;
      end
   end

   assign bus.o_cmd_ready      = (state_q == S_IDLE) && !i_rst;
   assign bus.o_rsp_valid      = (state_q == S_RESP);
   assign bus.o_rsp_err        = rsp_err_q;
   assign bus.o_rx_data        = rx_q;
   assign bus.o_ack_received   = ack_rx_q;
   assign bus.o_busy           = (state_q != S_IDLE);
   assign bus.o_bus_owned      = owned_q;
   assign bus.o_scl_oe         = scl_oe;
   assign bus.o_sda_oe         = sda_oe;
   assign bus.o_sr_load        = sr_load;
   assign bus.o_sr_parallel_in = tx_q;
   assign bus.o_sr_shift_en    = sr_shift;
   assign bus.o_sr_rw_mode     = is_read &&
                                 (state_q inside {S_PREP, S_DATA, S_ACK});
   assign bus.o_sr_ack_en      = ack_en_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb_i2c_byte_sequencer: directed bench for i2c_byte_sequencer.
// Includes a TX shift-register model and a slave that can ACK.
module tb_i2c_byte_sequencer;
   localparam int DW = 8;
   localparam int PW = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         cyc = 0;
   int         t_acc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] tb_sr;
   logic [7:0] rd_byte = 8'h00;
   logic       slave_ack = 1'b0;
   int         ack_lo = 0;
   int         ack_hi = 0;
   logic       slave_pull;

   i2c_byte_sequencer_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

   i2c_byte_sequencer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .i_sys_clk(clk),
      .i_rst    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) tb_sr <= 8'h00;
      else if (bus.o_sr_load) tb_sr <= bus.o_sr_parallel_in;
      else if (bus.o_sr_shift_en && !bus.o_sr_rw_mode)
         tb_sr <= {tb_sr[6:0], 1'b0};
   end

   assign slave_pull = slave_ack && ((cyc - t_acc) >= ack_lo) &&
                       ((cyc - t_acc) < ack_hi);
   assign bus.i_sr_serial_out   = tb_sr[7];
   assign bus.i_sr_parallel_out = rd_byte;
   assign bus.i_sda_in          = ~(bus.o_sda_oe | slave_pull);

   task automatic send(input logic [1:0] c, input logic [7:0] d,
                       input logic ae, input logic [15:0] ps);
      @(negedge clk);
      n_cmp++;
      if (bus.o_cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_before_cmd: got %b want 1", bus.o_cmd_ready);
      end
      bus.i_cmd        = c;
      bus.i_tx_data    = d;
      bus.i_cmd_ack_en = ae;
      bus.i_prescale   = ps;
      bus.i_cmd_valid  = 1'b1;
      t_acc = cyc;
      @(posedge clk);
      #1;
      bus.i_cmd_valid  = 1'b0;
      bus.i_tx_data    = ~d;
      bus.i_cmd_ack_en = ~ae;
      bus.i_prescale   = ps ^ 16'h0005;
   endtask

   task automatic test_reset();
      logic [11:0] got;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      got = {bus.o_cmd_ready, bus.o_scl_oe, bus.o_sda_oe, bus.o_busy,
             bus.o_bus_owned, bus.o_rsp_valid, bus.o_rsp_err,
             bus.o_ack_received, bus.o_sr_load, bus.o_sr_shift_en,
             bus.o_sr_rw_mode, bus.o_sr_ack_en};
      n_cmp++;
      if (got !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 000000000000", got);
      end
      n_cmp++;
      if ({bus.o_rx_data, bus.o_sr_parallel_in} !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0000",
                  {bus.o_rx_data, bus.o_sr_parallel_in});
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.o_cmd_ready, bus.o_busy, bus.o_rsp_valid} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_release: got %b want 100",
                  {bus.o_cmd_ready, bus.o_busy, bus.o_rsp_valid});
      end
   endtask

   task automatic test_error(input logic [1:0] c);
      logic [6:0] got;
      send(c, 8'h99, 1'b0, 16'd2);
      @(negedge clk);
      got = {bus.o_rsp_valid, bus.o_rsp_err, bus.o_busy, bus.o_scl_oe,
             bus.o_sda_oe, bus.o_sr_load, bus.o_sr_shift_en};
      n_cmp++;
      if (got !== 7'b1110000) begin
         n_bad++;
         $display("FAIL error_rsp cmd%0d: got %b want 1110000", c, got);
      end
      @(negedge clk);
      got = {bus.o_rsp_valid, bus.o_rsp_err, bus.o_busy, bus.o_cmd_ready,
             bus.o_scl_oe, bus.o_sda_oe, bus.o_bus_owned};
      n_cmp++;
      if (got !== 7'b0101000) begin
         n_bad++;
         $display("FAIL error_after cmd%0d: got %b want 0101000", c, got);
      end
   endtask

   task automatic test_start(input logic [15:0] ps);
      int q;
      int qi;
      logic [3:0] got;
      logic [3:0] exp;
      q = int'(ps) + 1;
      send(2'd0, 8'h00, 1'b0, ps);
      for (int k = 1; k <= 4 * q + 2; k++) begin
         @(negedge clk);
         if (k <= 4 * q) begin
            qi  = (k - 1) / q;
            got = {bus.o_scl_oe, bus.o_sda_oe, bus.o_rsp_valid, bus.o_busy};
            exp = {qi == 0 || qi == 3, qi >= 2, 1'b0, 1'b1};
         end else if (k == 4 * q + 1) begin
            got = {bus.o_rsp_valid, bus.o_rsp_err, bus.o_scl_oe, bus.o_sda_oe};
            exp = 4'b1011;
         end else begin
            got = {bus.o_cmd_ready, bus.o_bus_owned, bus.o_scl_oe, bus.o_busy};
            exp = 4'b1110;
         end
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL start_k%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_stop(input logic [15:0] ps);
      int q;
      int qi;
      logic [4:0] got;
      logic [4:0] exp;
      q = int'(ps) + 1;
      send(2'd3, 8'h00, 1'b0, ps);
      for (int k = 1; k <= 4 * q + 2; k++) begin
         @(negedge clk);
         got = {bus.o_scl_oe, bus.o_sda_oe, bus.o_rsp_valid, bus.o_rsp_err,
                bus.o_bus_owned};
         if (k <= 4 * q) begin
            qi  = (k - 1) / q;
            exp = {qi == 0, qi < 2, 1'b0, 1'b0, 1'b1};
         end else if (k == 4 * q + 1) exp = 5'b00100;
         else exp = 5'b00000;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL stop_k%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_write(input logic [7:0] d, input logic [15:0] ps,
                             input logic sl_ack, input logic pre_sda);
      int q, tot, b, off;
      logic bitv, shv;
      logic [6:0] got;
      logic [6:0] exp;
      q = int'(ps) + 1;
      tot = 4 + 36 * q;
      slave_ack = sl_ack;
      ack_lo = 4 + 32 * q;
      ack_hi = tot;
      send(2'd1, d, 1'b0, ps);
      for (int k = 1; k <= tot + 1; k++) begin
         @(negedge clk);
         got = {bus.o_scl_oe, bus.o_sda_oe, bus.o_sr_load, bus.o_sr_shift_en,
                bus.o_rsp_valid, bus.o_busy, bus.o_sr_rw_mode};
         if (k < 4) exp = {1'b1, pre_sda, k == 1, 1'b0, 1'b0, 1'b1, 1'b0};
         else if (k < tot) begin
            b   = (k - 4) / (4 * q);
            off = (k - 4) % (4 * q);
            if (b < 8) begin
               bitv = ~d[7 - b];
               shv  = (off == 3 * q - 1);
            end else begin
               bitv = 1'b0;
               shv  = (off == 0);
            end
            exp = {off < 2 * q, bitv, 1'b0, shv, 1'b0, 1'b1, 1'b0};
         end else if (k == tot) exp = 7'b1000110;
         else exp = 7'b1000000;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL write_k%0d: got %b want %b", k, got, exp);
         end
         if (k == 1) begin
            n_cmp++;
            if (bus.o_sr_parallel_in !== d) begin
               n_bad++;
               $display("FAIL write_pin: got %h want %h",
                        bus.o_sr_parallel_in, d);
            end
         end
         if (k == tot || k == tot + 1) begin
            n_cmp++;
            if ({bus.o_rsp_err, bus.o_ack_received} !== {1'b0, sl_ack}) begin
               n_bad++;
               $display("FAIL write_ack_k%0d: got %b want %b", k,
                        {bus.o_rsp_err, bus.o_ack_received}, {1'b0, sl_ack});
            end
         end
      end
      slave_ack = 1'b0;
   endtask

   task automatic test_read(input logic [7:0] rb, input logic ae,
                            input logic [15:0] ps);
      int q, tot, b, off;
      logic shv;
      logic [6:0] got;
      logic [6:0] exp;
      q = int'(ps) + 1;
      tot = 4 + 36 * q;
      rd_byte = rb;
      send(2'd2, 8'h00, ae, ps);
      for (int k = 1; k <= tot + 1; k++) begin
         @(negedge clk);
         got = {bus.o_scl_oe, bus.o_sda_oe, bus.o_sr_load, bus.o_sr_shift_en,
                bus.o_rsp_valid, bus.o_busy, bus.o_sr_rw_mode};
         if (k < 4) exp = {1'b1, 1'b0, k == 1, 1'b0, 1'b0, 1'b1, 1'b1};
         else if (k < tot) begin
            b   = (k - 4) / (4 * q);
            off = (k - 4) % (4 * q);
            shv = (b < 8) ? (off == 3 * q - 1) : (off == 0);
            exp = {off < 2 * q, (b == 8) & ae, 1'b0, shv, 1'b0, 1'b1, 1'b1};
         end else if (k == tot) exp = 7'b1000110;
         else exp = 7'b1000000;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL read_k%0d: got %b want %b", k, got, exp);
         end
         if (k == 1) begin
            n_cmp++;
            if (bus.o_sr_ack_en !== ae) begin
               n_bad++;
               $display("FAIL read_ack_en: got %b want %b", bus.o_sr_ack_en, ae);
            end
         end
         if (k == tot || k == tot + 1) begin
            n_cmp++;
            if ({bus.o_rx_data, bus.o_rsp_err, bus.o_ack_received} !==
                {rb, 2'b00}) begin
               n_bad++;
               $display("FAIL read_rsp_k%0d: got %h/%b%b want %h/00", k,
                        bus.o_rx_data, bus.o_rsp_err, bus.o_ack_received, rb);
            end
            rd_byte = ~rb;
         end
      end
   endtask

   task automatic test_nack_rstart();
      test_start(16'd0);
      test_write(8'h5A, 16'd0, 1'b0, 1'b1);
      test_start(16'd1);
      test_stop(16'd1);
   endtask

   task automatic test_reset_mid();
      logic [11:0] got;
      logic [6:0] idle;
      test_start(16'd1);
      send(2'd1, 8'hF0, 1'b0, 16'd1);
      for (int k = 1; k <= 40; k++) @(negedge clk);
      n_cmp++;
      if ({bus.o_busy, bus.o_scl_oe} !== 2'b10) begin
         n_bad++;
         $display("FAIL mid_phase_c: got %b want 10",
                  {bus.o_busy, bus.o_scl_oe});
      end
      #1 rst = 1'b1;
      #1;
      got = {bus.o_cmd_ready, bus.o_scl_oe, bus.o_sda_oe, bus.o_busy,
             bus.o_bus_owned, bus.o_rsp_valid, bus.o_rsp_err,
             bus.o_ack_received, bus.o_sr_load, bus.o_sr_shift_en,
             bus.o_sr_rw_mode, bus.o_sr_ack_en};
      n_cmp++;
      if (got !== 12'h000) begin
         n_bad++;
         $display("FAIL mid_reset_flags: got %b want 000000000000", got);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         idle = {bus.o_rsp_valid, bus.o_sr_load, bus.o_sr_shift_en,
                 bus.o_scl_oe, bus.o_sda_oe, bus.o_busy, bus.o_bus_owned};
         n_cmp++;
         if (idle !== 7'b0000000) begin
            n_bad++;
            $display("FAIL post_reset_k%0d: got %b want 0000000", k, idle);
         end
      end
      test_error(2'd1);
   endtask

   initial begin
      bus.i_cmd_valid  = 1'b0;
      bus.i_cmd        = 2'd0;
      bus.i_cmd_ack_en = 1'b0;
      bus.i_tx_data    = 8'h00;
      bus.i_prescale   = 16'd0;
      test_reset();
      test_error(2'd1);
      test_error(2'd3);
      test_start(16'd3);
      test_write(8'hA5, 16'd1, 1'b1, 1'b1);
      test_read(8'h3C, 1'b0, 16'd0);
      test_read(8'hC3, 1'b1, 16'd2);
      test_stop(16'd0);
      test_nack_rstart();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_byte_sequencer.md
# i2c_byte_sequencer

Command-driven I2C master bit-timing controller. It sequences the I2C byte shift register: it issues load, shift-enable, direction and ACK-enable strobes, generates SCL, drives SDA as open-drain enables, and returns one response per command. It sits between the APB register front end, which supplies commands, and the I2C pads/shift register. Clock stretching and multi-master arbitration are out of scope.

## Interface
- `DATA_WIDTH`, 8, byte width.
- `PRESCALE_WIDTH`, 16, width of quarter-period divider.
- `i_sys_clk`  input  1  system clock (APB PCLK).
- `i_rst`  input  1  asynchronous, active-high reset.
- `i_prescale`  input  PRESCALE_WIDTH  quarter-period Q = i_prescale+1 sys clocks; latched at command accept.
- `i_cmd_valid`  input  1  command request.
- `o_cmd_ready`  output  1  command accepted when valid&ready.
- `i_cmd`  input  2  0=START, 1=WRITE, 2=READ, 3=STOP.
- `i_cmd_ack_en`  input  1  READ only: 1 drive ACK, 0 send NACK.
- `i_tx_data`  input  DATA_WIDTH  WRITE byte.
- `o_rsp_valid`  output  1  one-cycle completion pulse.
- `o_rsp_err`  output  1  command rejected (protocol error).
- `o_rx_data`  output  DATA_WIDTH  READ byte.
- `o_ack_received`  output  1  WRITE: slave drove ACK (SDA low).
- `o_busy`  output  1  command in progress.
- `o_bus_owned`  output  1  START issued, no STOP yet.
- `o_scl_oe`  output  1  1 = pull SCL low.
- `o_sda_oe`  output  1  1 = pull SDA low.
- `i_sda_in`  input  1  synchronized SDA pad level.
- `o_sr_load`  output  1  shift-register load strobe.
- `o_sr_parallel_in`  output  DATA_WIDTH  latched i_tx_data.
- `o_sr_shift_en`  output  1  shift strobe.
- `o_sr_rw_mode`  output  1  0 TX, 1 RX.
- `o_sr_ack_en`  output  1  latched i_cmd_ack_en.
- `i_sr_serial_out`  input  1  shift-register MSB.
- `i_sr_parallel_out`  input  DATA_WIDTH  shift-register contents.

## Operation
- States: IDLE, START, PREP, DATA, ACK, STOP, RESP.
- o_cmd_ready = 1 only in IDLE. Accept latches cmd, prescale, tx_data and ack_en.
- Quarter counter counts Q cycles per quarter. Each bit has 4 quarters: A, B (SCL low), then C, D (SCL released).
- START quarters (SCL,SDA released=1): (0,1) (1,1) (1,0) (0,0). Valid as first START and as repeated START. Sets bus_owned.
- STOP quarters: (0,0) (1,0) (1,1) (1,1). Clears bus_owned and leaves the bus released.
- WRITE/READ with bus_owned=0, or STOP with bus_owned=0: no bus activity, RESP with o_rsp_err=1.
- Byte command flow:
  - PREP: o_sr_load pulses the cycle after accept.
  - DATA: 8 bits, MSB first.
    - WRITE: o_sda_oe = ~i_sr_serial_out, sampled at the first cycle of phase A and held for the bit.
    - READ: SDA released.
    - o_sr_shift_en pulses at the last cycle of phase C for bits 0..7.
    - o_sr_rw_mode holds for the whole byte.
  - ACK: 9th bit. o_sr_shift_en pulses once at the first cycle of its phase A (byte finalize).
    - WRITE: SDA released; i_sda_in sampled at the last cycle of phase C, o_ack_received = ~i_sda_in.
    - READ: o_sda_oe = i_cmd_ack_en.
- RESP (one cycle):
  - o_rsp_valid = 1.
  - READ: o_rx_data <= i_sr_parallel_out.
  - o_rsp_err, o_rx_data and o_ack_received hold until the next response.
  - Returns to IDLE.
- After a byte, SCL is left low (phase-D exit drives SCL low for next command) and SDA is released.
- Reset values: o_scl_oe=0, o_sda_oe=0, o_cmd_ready=0 during reset then 1, o_rsp_valid=0, o_rsp_err=0, o_rx_data=0, o_ack_received=0, o_busy=0, o_bus_owned=0, all o_sr_* = 0.

## Timing
- Accept at cycle T. Response pulse o_rsp_valid at:
  - START/STOP: T+1+4Q.
  - WRITE/READ: T+4+36Q.
  - Error: T+1.
- o_busy = 1 from T+1 through the RESP cycle. o_cmd_ready returns to 1 the cycle after RESP.
- PREP: o_sr_load at T+1; bit 0 phase A starts at T+4.
- i_prescale=0 → Q=1; maximum Q = 2^PRESCALE_WIDTH.
- Changes to i_prescale, i_tx_data or i_cmd_ack_en mid-command have no effect.
- i_cmd_valid while busy is ignored until ready.
- Async reset mid-command:
  - Both oe signals are released immediately and bus_owned cleared.
  - No response is issued and no strobe is generated.
  - The bus is left released; a STOP is not synthesized.

## Test plan
- Reset then START, prescale=3 (Q=4) → SCL/SDA sequence (0,1)(1,1)(1,0)(0,0), 4 cycles each; rsp_valid at T+17; o_bus_owned=1; rsp_err=0.
- WRITE 0xA5, slave ACKs, Q=2:
  - o_sda_oe bits 0,1,0,1,1,0,1,0 (invert of 1010_0101).
  - 9 o_sr_shift_en pulses; o_sr_load at T+1.
  - rsp at T+76 with o_ack_received=1.
- READ with slave driving 0x3C, ack_en=0 → o_rx_data=0x3C, SDA released in ACK bit (NACK), o_sr_rw_mode=1 throughout.
- WRITE before any START → rsp_valid at T+1, rsp_err=1, o_scl_oe/o_sda_oe stay 0, no o_sr_* strobes.
- START, WRITE (slave NACK: SDA high), repeated START, STOP → o_ack_received=0; repeated START produces an SDA falling edge with SCL high; after STOP both lines are released and o_bus_owned=0.
- Assert i_rst mid-byte (bit 4, phase C) → outputs take reset values the same cycle, no rsp_valid; a subsequent WRITE returns rsp_err=1.
